// File: rtl/adder_bist_if.sv
// Operand/result bus between the BIST engine and the adder under test.
interface adder_bist_if #(
  parameter int unsigned WIDTH = 6
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (output x, y, input  s, cout);
  modport slave  (input  x, y, output s, cout);
endinterface

// File: rtl/adder_bist.sv
// Exhaustive BIST for a WIDTH-bit adder: sweeps every {x,y} pair, checks {cout,s}
// against x+y, and reports a saturating mismatch count plus the first failing vector.
module adder_bist #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  adder_bist_if.master         bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic                 first_err_valid,
  output logic [2*WIDTH-1:0]   first_err_idx,
  output logic [WIDTH:0]       first_err_got
);

  localparam int unsigned IDX_W = 2 * WIDTH;
  localparam int unsigned RES_W = WIDTH + 1;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(SETTLE - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_APPLY = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic [RES_W-1:0] fgot_q, fgot_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [RES_W-1:0] exp_sum;
  logic [RES_W-1:0] got;
  logic             mismatch;

  // Next-state, sweep and result bookkeeping.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fv_d     = fv_q;
    fidx_d   = fidx_q;
    fgot_d   = fgot_q;
    pass_d   = pass_q;
    exp_sum  = {1'b0, x_q} + {1'b0, y_q};
    got      = {bus.cout, bus.s};
    // Case inequality so an unknown adder output is flagged rather than ignored.
    mismatch = (got !== exp_sum);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_APPLY;
          idx_d   = '0;
          x_d     = '0;
          y_d     = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          fidx_d  = '0;
          fgot_d  = '0;
          pass_d  = 1'b0;
        end
      end
      S_APPLY: begin
        cnt_d   = '0;
        state_d = (SETTLE == 0) ? S_CHECK : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + ERR_W'(1);
          end
          if (!fv_q) begin
            fv_d   = 1'b1;
            fidx_d = idx_q;
            fgot_d = got;
          end
        end
        if (idx_q == '1) begin
          state_d = S_DONE;
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          x_d     = idx_d[IDX_W-1:WIDTH];
          y_d     = idx_d[WIDTH-1:0];
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_APPLY) || (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fidx_q  <= '0;
      fgot_q  <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fidx_q  <= fidx_d;
      fgot_q  <= fgot_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fv_q;
  assign first_err_idx   = fidx_q;
  assign first_err_got   = fgot_q;

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: a behavioural adder with selectable faults feeds the BIST,
// and final reports are compared against a table of expected results.
module tb_adder_bist;

  typedef struct {
    int mode;
    int bx;
    int bylo;
    int pat;
    int restart_at;
    int err;
    int fv;
    int fidx;
    int fgot;
    int pass;
  } vec_t;

  logic clk;
  logic rst_n;
  logic start_b;
  logic start_s;

  int checks;
  int errors;

  int mode_b, bx_b, bylo_b, pat_b;
  logic inv_s;

  adder_bist_if #(.WIDTH(6)) bus_b ();
  adder_bist_if #(.WIDTH(2)) bus_s ();

  logic        busy_b, done_b, pass_b, fv_b;
  logic [12:0] err_b;
  logic [11:0] fidx_b;
  logic [6:0]  fgot_b;

  logic        busy_s, done_s, pass_s, fv_s;
  logic [2:0]  err_s;
  logic [3:0]  fidx_s;
  logic [2:0]  fgot_s;

  adder_bist u_big (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bus(bus_b.master),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_valid(fv_b), .first_err_idx(fidx_b), .first_err_got(fgot_b)
  );

  adder_bist #(.WIDTH(2), .SETTLE(0), .ERR_W(3)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .bus(bus_s.master),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
    .first_err_valid(fv_s), .first_err_idx(fidx_s), .first_err_got(fgot_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder under test with injectable faults; result is {cout,s}.
  function automatic logic [6:0] adder_fn(input int mode, input logic [5:0] x, input logic [5:0] y,
                                          input int bx, input int bylo, input int pat);
    logic [6:0] r;
    r = 7'(int'(x) + int'(y));
    case (mode)
      1: r[6] = 1'b0;
      2: r[0] = ~r[0];
      3: if (int'(x) == bx && int'(y) >= bylo) r = r ^ 7'(pat);
      default: ;
    endcase
    return r;
  endfunction

  always_comb {bus_b.cout, bus_b.s} = adder_fn(mode_b, bus_b.x, bus_b.y, bx_b, bylo_b, pat_b);
  always_comb {bus_s.cout, bus_s.s} = 3'(int'(bus_s.x) + int'(bus_s.y)) ^ (inv_s ? 3'b001 : 3'b000);

  // Reference: walk every operand pair in sweep order with integer arithmetic.
  function automatic void ref_run(input int mode, input int bx, input int bylo, input int pat,
                                  output int err, output int fv, output int fidx, output int fgot);
    err = 0; fv = 0; fidx = 0; fgot = 0;
    for (int xi = 0; xi < 64; xi++) begin
      for (int yi = 0; yi < 64; yi++) begin
        int g;
        g = int'(adder_fn(mode, 6'(xi), 6'(yi), bx, bylo, pat));
        if (g != xi + yi) begin
          err++;
          if (fv == 0) begin
            fv = 1; fidx = xi * 64 + yi; fgot = g;
          end
        end
      end
    end
    if (err > 8191) err = 8191;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_big_reset(input string tag);
    check({tag, " busy"},  int'(busy_b), 0);
    check({tag, " done"},  int'(done_b), 0);
    check({tag, " pass"},  int'(pass_b), 0);
    check({tag, " err"},   int'(err_b), 0);
    check({tag, " fv"},    int'(fv_b), 0);
    check({tag, " fidx"},  int'(fidx_b), 0);
    check({tag, " fgot"},  int'(fgot_b), 0);
    check({tag, " xy"},    int'({bus_b.x, bus_b.y}), 0);
  endtask

  // Start a full sweep on the big instance; optionally re-pulse start or reset mid-run.
  task automatic run_big(input vec_t e, input int abort_at);
    int cycles;
    mode_b = e.mode; bx_b = e.bx; bylo_b = e.bylo; pat_b = e.pat;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check("start done_low", int'(done_b), 0);
    check("start busy",     int'(busy_b), 1);
    check("start err_clr",  int'(err_b), 0);
    check("start fv_clr",   int'(fv_b), 0);
    check("start xy0",      int'({bus_b.x, bus_b.y}), 0);
    cycles = 0;
    while (!done_b && cycles < 20000) begin
      if (cycles == e.restart_at) start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      cycles++;
      if (cycles == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_big_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    check("done_latency", cycles, 16384);
    check("busy_in_done", int'(busy_b), 0);
    check("pass",         int'(pass_b), e.pass);
    check("err_count",    int'(err_b), e.err);
    check("first_valid",  int'(fv_b), e.fv);
    check("first_idx",    int'(fidx_b), e.fidx);
    check("first_got",    int'(fgot_b), e.fgot);
    check("last_xy",      int'({bus_b.x, bus_b.y}), 12'hfff);
    repeat (3) @(negedge clk);
    check("done_held",    int'(done_b), 1);
  endtask

  task automatic run_small(input logic inv, input int exp_err, input int exp_fv,
                           input int exp_fgot, input int exp_pass);
    int cycles;
    inv_s = inv;
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    check("small start done_low", int'(done_s), 0);
    cycles = 0;
    while (!done_s && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("small latency", cycles, 32);
    check("small err",     int'(err_s), exp_err);
    check("small fv",      int'(fv_s), exp_fv);
    check("small fidx",    int'(fidx_s), 0);
    check("small fgot",    int'(fgot_s), exp_fgot);
    check("small pass",    int'(pass_s), exp_pass);
  endtask

  vec_t tbl[4];

  initial begin
    vec_t abort_v;
    int e_err, e_fv, e_fidx, e_fgot;
    checks = 0; errors = 0;
    rst_n = 1'b0; start_b = 1'b0; start_s = 1'b0;
    mode_b = 0; bx_b = 0; bylo_b = 0; pat_b = 0; inv_s = 1'b0;

    tbl[0] = '{mode: 0, bx: 0, bylo: 0, pat: 0, restart_at: -1, err: 0,    fv: 0, fidx: 0,   fgot: 0, pass: 1};
    tbl[1] = '{mode: 1, bx: 0, bylo: 0, pat: 0, restart_at: -1, err: 2016, fv: 1, fidx: 127, fgot: 0, pass: 0};
    tbl[2] = '{mode: 2, bx: 0, bylo: 0, pat: 0, restart_at: -1, err: 4096, fv: 1, fidx: 0,   fgot: 1, pass: 0};
    tbl[3].mode = 3;
    tbl[3].bx   = int'($urandom_range(0, 63));
    tbl[3].bylo = int'($urandom_range(0, 63));
    tbl[3].pat  = int'($urandom_range(1, 127));
    tbl[3].restart_at = 2000;
    ref_run(3, tbl[3].bx, tbl[3].bylo, tbl[3].pat, e_err, e_fv, e_fidx, e_fgot);
    tbl[3].err = e_err; tbl[3].fv = e_fv; tbl[3].fidx = e_fidx; tbl[3].fgot = e_fgot;
    tbl[3].pass = (e_err == 0) ? 1 : 0;

    repeat (3) @(negedge clk);
    check_big_reset("reset");
    check("reset small done", int'(done_s), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset around vector 100 of a faulty run wipes everything.
    abort_v = tbl[2];
    run_big(abort_v, 400);

    for (int i = 0; i < 4; i++) run_big(tbl[i], -1);

    run_small(1'b1, 7, 1, 1, 0);
    run_small(1'b0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
